// File: rtl/tick_rate_ctrl.sv
// Run/stop and rate controller: one period counter producing a divided clock and a
// one-cycle tick, with divisor updates taken over valid/ready and applied at period boundaries.
module tick_rate_ctrl #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 100000000,
    parameter int unsigned MIN_DIV     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             tick,
    output logic             out_clk,
    output logic [CNT_W-1:0] cur_div,
    output logic             busy
);

    localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] MIN_DIV_C = CNT_W'(MIN_DIV);

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_PEND
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             out_clk_q, out_clk_d;
    logic             tick_q, tick_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             cfg_err_q, cfg_err_d;
    logic             busy_q, busy_d;

    logic             xfer;
    logic             legal;
    logic             wrap;
    logic [CNT_W-1:0] cnt_step;

    always_comb begin
        xfer     = cfg_valid & cfg_ready_q;
        legal    = (cfg_div >= MIN_DIV_C);
        wrap     = (cnt_q >= (cur_div_q - CNT_W'(1)));
        cnt_step = wrap ? '0 : cnt_q + CNT_W'(1);

        state_d    = state_q;
        cnt_d      = '0;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        tick_d     = 1'b0;
        cfg_err_d  = xfer & ~legal;

        case (state_q)
            ST_STOP: begin
                if (xfer && legal) cur_div_d = cfg_div;
                if (en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!en) begin
                    // Stopping and a transfer on the same edge: load the divisor directly.
                    state_d = ST_STOP;
                    if (xfer && legal) cur_div_d = cfg_div;
                end else begin
                    cnt_d  = cnt_step;
                    tick_d = wrap;
                    if (xfer && legal) begin
                        pend_div_d = cfg_div;
                        state_d    = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (!en) begin
                    state_d   = ST_STOP;
                    cur_div_d = pend_div_q;
                end else begin
                    cnt_d  = cnt_step;
                    tick_d = wrap;
                    if (wrap) begin
                        cur_div_d = pend_div_q;
                        state_d   = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_STOP;
            end
        endcase

        out_clk_d   = (state_d != ST_STOP) && (cnt_d < (cur_div_d >> 1));
        cfg_ready_d = (state_d != ST_PEND);
        busy_d      = (state_d != ST_STOP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_STOP;
            cnt_q       <= '0;
            cur_div_q   <= DEF_DIV_C;
            pend_div_q  <= '0;
            out_clk_q   <= 1'b0;
            tick_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_div_q   <= cur_div_d;
            pend_div_q  <= pend_div_d;
            out_clk_q   <= out_clk_d;
            tick_q      <= tick_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
            busy_q      <= busy_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = cfg_err_q;
    assign tick      = tick_q;
    assign out_clk   = out_clk_q;
    assign cur_div   = cur_div_q;
    assign busy      = busy_q;

endmodule
